// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: IF fetch channel, LSU data channel and the
// memory-side issue/return signals. slave = arbiter side, master = clients + memory.
interface mem_port_arbiter_if;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        i_if_kill;
   logic [31:0] o_if_rdata;
   logic        o_if_valid;
   logic        o_if_stall;

   logic        i_lsu_req;
   logic        i_lsu_wren;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_lsu_wdata;
   logic [3:0]  i_lsu_bmask;
   logic [31:0] o_lsu_rdata;
   logic        o_lsu_valid;
   logic        o_lsu_stall;

   logic        o_mem_req;
   logic        o_mem_wren;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask;
   logic [31:0] i_mem_rdata;

   modport slave (
      input  i_if_req, i_if_addr, i_if_kill,
      output o_if_rdata, o_if_valid, o_if_stall,
      input  i_lsu_req, i_lsu_wren, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
      output o_lsu_rdata, o_lsu_valid, o_lsu_stall,
      output o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
      input  i_mem_rdata
   );

   modport master (
      output i_if_req, i_if_addr, i_if_kill,
      input  o_if_rdata, o_if_valid, o_if_stall,
      output i_lsu_req, i_lsu_wren, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
      input  o_lsu_rdata, o_lsu_valid, o_lsu_stall,
      input  o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
      output i_mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single shared memory port (IF vs LSU).
// Fixed-latency access tracking with a one-cycle completion pulse per requester.
// Optional macro ARB_FAIRNESS_EN: bounds consecutive LSU grants while IF waits.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's fields into the o_mem_* registers
// ISSUE   | o_mem_req strobe; load latency down-counter
// WAIT    | count down; completion (rdata/valid) when cnt reaches 0
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic               i_clk,
   input logic               i_reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY out of range 1..15");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
   end

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_owner_lsu;
   logic        r_killed;
   logic [3:0]  r_cnt;
   logic        r_mem_wren;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_bmask;
   logic        w_grant_lsu;
   logic        w_grant_if;
   logic        w_prefer_if;
   logic        w_done;
   logic        w_if_valid;
   logic        w_lsu_valid;

`ifdef ARB_FAIRNESS_EN
   logic [3:0] r_starve;

   assign w_prefer_if = (r_starve == 4'(STARVE_LIMIT));

   // Starvation counter: consecutive LSU grants taken while IF was waiting
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_starve <= 4'd0;
      end else if (!bus.i_if_req || w_grant_if) begin
         r_starve <= 4'd0;
      end else if (w_grant_lsu) begin
         r_starve <= r_starve + 4'd1;
      end
   end
`else
   assign w_prefer_if = 1'b0;
`endif

   // Next-state and arbitration; LSU wins ties since it holds the older instruction
   always_comb begin
      w_state_nxt = r_state;
      w_grant_lsu = 1'b0;
      w_grant_if  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant_lsu = bus.i_lsu_req & ~(w_prefer_if & bus.i_if_req);
            w_grant_if  = bus.i_if_req & ~w_grant_lsu;
            if (w_grant_lsu || w_grant_if) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any access in flight
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Access fields, latency counter and kill flag
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_owner_lsu <= 1'b0;
         r_killed    <= 1'b0;
         r_cnt       <= 4'd0;
         r_mem_wren  <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_bmask <= 4'd0;
      end else begin
         if (w_grant_lsu) begin
            r_owner_lsu <= 1'b1;
            r_mem_wren  <= bus.i_lsu_wren;
            r_mem_addr  <= bus.i_lsu_addr;
            r_mem_wdata <= bus.i_lsu_wdata;
            r_mem_bmask <= bus.i_lsu_bmask;
         end else if (w_grant_if) begin
            r_owner_lsu <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= bus.i_if_addr;
            r_mem_wdata <= 32'd0;
            r_mem_bmask <= 4'hF;
         end

         if (r_state == S_ISSUE) begin
            r_cnt <= 4'(MEM_LATENCY - 1);
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // The killed fetch still runs to completion to keep memory timing intact
         if (r_state == S_IDLE) begin
            r_killed <= 1'b0;
         end else if (!r_owner_lsu && bus.i_if_kill) begin
            r_killed <= 1'b1;
         end
      end
   end

   assign w_done      = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_if_valid  = w_done & ~r_owner_lsu & ~r_killed & ~bus.i_if_kill & i_reset;
   assign w_lsu_valid = w_done & r_owner_lsu & i_reset;

   assign bus.o_if_valid  = w_if_valid;
   assign bus.o_if_rdata  = w_if_valid ? bus.i_mem_rdata : 32'd0;
   assign bus.o_if_stall  = bus.i_if_req & ~w_if_valid;
   assign bus.o_lsu_valid = w_lsu_valid;
   assign bus.o_lsu_rdata = (w_lsu_valid && !r_mem_wren) ? bus.i_mem_rdata : 32'd0;
   assign bus.o_lsu_stall = bus.i_lsu_req & ~w_lsu_valid;
   assign bus.o_mem_req   = (r_state == S_ISSUE);
   assign bus.o_mem_wren  = r_mem_wren;
   assign bus.o_mem_addr  = r_mem_addr;
   assign bus.o_mem_wdata = r_mem_wdata;
   assign bus.o_mem_bmask = r_mem_bmask;

endmodule
